// File: rtl/tens_trans_seq_dispatch.sv
// sync_fifo: single-clock FIFO with occupancy count, used as the dispatcher's output buffer.
// Latency: 1 cycle push-to-head (registered storage, combinational head read).
// Backpressure: push is dropped only when full with no pop in the same cycle; push+pop allowed at full and at empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && ((cnt != (AW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_dat;
    end

    assign pop_dat = mem[rptr];
    assign empty   = (cnt == '0);
    assign count   = cnt;
endmodule

// tens_trans_seq_dispatch: H2C transfer dispatcher. Takes one descriptor at a time; on a new
// sequence index waits for the accelerator to go idle and requests a regmap load, then streams
// len buffer words onto the selected AXI-stream channel.
// Latency: first beat RD_LAT+1 cycles after entering STREAM; 1 beat/cycle sustained with tready=1.
// Backpressure: desc_ready low until the previous descriptor fully drains; buffer reads are
// credit-limited by FIFO occupancy plus reads in flight, so tready stalls never drop data.
// Ports: desc_* descriptor handshake; accel_busy/cfg_* regmap load handshake; mem_rd_* buffer
// read port (fixed RD_LAT); m_axis_* shared-data per-channel stream; busy/err_len/seq_cnt status.
module tens_trans_seq_dispatch #(
    parameter int DATA_WDT   = 64,
    parameter int ADDR_WDT   = 16,
    parameter int LEN_WDT    = 16,
    parameter int SEQ_WDT    = 8,
    parameter int N_CH       = 2,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                desc_valid,
    output logic                desc_ready,
    input  logic [SEQ_WDT-1:0]  desc_seq,
    input  logic [CH_W-1:0]     desc_ch,
    input  logic [ADDR_WDT-1:0] desc_offs,
    input  logic [LEN_WDT-1:0]  desc_len,
    input  logic                accel_busy,
    output logic                cfg_req,
    output logic [SEQ_WDT-1:0]  cfg_seq,
    input  logic                cfg_ack,
    output logic                mem_rd_en,
    output logic [ADDR_WDT-1:0] mem_rd_addr,
    input  logic [DATA_WDT-1:0] mem_rd_data,
    output logic [DATA_WDT-1:0] m_axis_tdata,
    output logic [N_CH-1:0]     m_axis_tvalid,
    output logic [N_CH-1:0]     m_axis_tlast,
    input  logic [N_CH-1:0]     m_axis_tready,
    output logic                busy,
    output logic                err_len,
    output logic [15:0]         seq_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_IDLE = 3'd1,
        CFG       = 3'd2,
        STREAM    = 3'd3,
        DRAIN     = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // latched descriptor
    logic [SEQ_WDT-1:0]  seq_q;
    logic [CH_W-1:0]     ch_q;
    logic [ADDR_WDT-1:0] offs_q;
    logic [LEN_WDT-1:0]  len_q;
    logic [LEN_WDT-1:0]  issued_cnt;

    logic [SEQ_WDT-1:0]  cur_seq;
    logic                cur_seq_vld;
    logic                accel_busy_q;
    logic [15:0]         seq_cnt_q;
    logic                err_len_q;
    logic                last_done;

    // read pipeline: one valid/last tag per outstanding buffer read
    logic [RD_LAT-1:0]   vld_pipe;
    logic [RD_LAT-1:0]   last_pipe;
    logic [CW-1:0]       inflight;

    logic                new_seq;
    logic                rd_issue;
    logic                rd_final;
    logic                push;
    logic                pop;
    logic [CW-1:0]       fifo_count;
    logic [CW:0]         credit_used;
    logic                fifo_empty;
    logic [DATA_WDT-1:0] head_dat;
    logic                head_last;
    logic [N_CH-1:0]     ch_mask;

    assign new_seq     = !cur_seq_vld || (desc_seq != cur_seq);
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    // Reads already in flight hold a FIFO slot, so the FIFO can never overflow.
    assign rd_issue    = (state == STREAM) && (issued_cnt < len_q) &&
                         (credit_used < (CW+1)'(FIFO_DEPTH));
    assign rd_final    = rd_issue && (issued_cnt == len_q - LEN_WDT'(1));
    assign push        = vld_pipe[RD_LAT-1];
    assign ch_mask     = N_CH'(1) << ch_q;
    assign pop         = !fifo_empty && |(m_axis_tready & ch_mask);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (desc_valid && (desc_len != '0))
                    state_nxt = new_seq ? WAIT_IDLE : STREAM;
            end
            WAIT_IDLE: if (!accel_busy_q) state_nxt = CFG;
            CFG:       if (cfg_ack)       state_nxt = STREAM;
            STREAM:    if (rd_final)      state_nxt = DRAIN;
            DRAIN: begin
                if (fifo_empty && (inflight == '0) && last_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        // Gated by rst so every output reads 0 while reset is held.
        desc_ready  = (state == IDLE) && !rst;
        cfg_req     = (state == CFG);
        cfg_seq     = (state == CFG) ? seq_q : '0;
        mem_rd_en   = rd_issue;
        mem_rd_addr = offs_q + ADDR_WDT'(issued_cnt);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q        <= '0;
            ch_q         <= '0;
            offs_q       <= '0;
            len_q        <= '0;
            issued_cnt   <= '0;
            cur_seq      <= '0;
            cur_seq_vld  <= 1'b0;
            accel_busy_q <= 1'b0;
            seq_cnt_q    <= '0;
            err_len_q    <= 1'b0;
            last_done    <= 1'b0;
            vld_pipe     <= '0;
            last_pipe    <= '0;
            inflight     <= '0;
        end else begin
            accel_busy_q <= accel_busy;

            if ((state == IDLE) && desc_valid) begin
                if (desc_len == '0) begin
                    err_len_q <= 1'b1;
                end else begin
                    seq_q      <= desc_seq;
                    ch_q       <= desc_ch;
                    offs_q     <= desc_offs;
                    len_q      <= desc_len;
                    issued_cnt <= '0;
                    last_done  <= 1'b0;
                end
            end

            if ((state == CFG) && cfg_ack) begin
                cur_seq     <= seq_q;
                cur_seq_vld <= 1'b1;
                seq_cnt_q   <= seq_cnt_q + 16'd1;
            end

            if (rd_issue) issued_cnt <= issued_cnt + LEN_WDT'(1);

            vld_pipe[0]  <= rd_issue;
            last_pipe[0] <= rd_final;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end

            case ({rd_issue, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase

            if (pop && head_last) last_done <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_WDT + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({last_pipe[RD_LAT-1], mem_rd_data}),
        .pop      (pop),
        .pop_dat  ({head_last, head_dat}),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign m_axis_tdata  = fifo_empty ? '0 : head_dat;
    assign m_axis_tvalid = fifo_empty ? '0 : ch_mask;
    assign m_axis_tlast  = (!fifo_empty && head_last) ? ch_mask : '0;
    assign busy          = (state != IDLE) || !fifo_empty;
    assign err_len       = err_len_q;
    assign seq_cnt       = seq_cnt_q;
endmodule
